// File: rtl/fo_issue_control.sv
// Operand-fetch issue controller: decodes fetched instruction words into the
// registered FO/EX control bundle and paces issue around loads, long ops and stalls.
module fo_issue_control #(
  parameter int unsigned MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        issue_valid,
  output logic        mux4,
  output logic [2:0]  mux5,
  output logic [2:0]  mux6,
  output logic [2:0]  reg_bank,
  output logic        data_mem,
  output logic        reg_flags,
  output logic [5:0]  alu
);

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  typedef struct packed {
    logic       issue_valid;
    logic       mux4;
    logic [2:0] mux5;
    logic [2:0] mux6;
    logic [2:0] reg_bank;
    logic       data_mem;
    logic       reg_flags;
    logic [5:0] alu;
  } bundle_t;

  localparam bundle_t    BUBBLE   = '0;
  localparam logic [5:0] OP_NOP   = 6'b111111;
  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_pend_q, load_pend_d;
  logic [2:0] load_rd_q, load_rd_d;
  bundle_t    bundle_q, bundle_d;

  logic [5:0] op;
  logic [2:0] rd, rs, rt;
  logic       unused_instr_bit;
  bundle_t    dec_bundle;
  logic       dec_is_load;
  logic       dec_is_multi;
  logic       hazard;

  assign op               = instr[15:10];
  assign rd               = instr[9:7];
  assign rs               = instr[6:4];
  assign rt               = instr[3:1];
  assign unused_instr_bit = instr[0];

  // Instruction class decode, independent of whether the word is accepted
  always_comb begin
    dec_bundle             = BUBBLE;
    dec_bundle.issue_valid = 1'b1;
    dec_is_load            = 1'b0;
    dec_is_multi           = 1'b0;
    unique case (op[5:4])
      2'b00: begin
        dec_bundle.alu       = op;
        dec_bundle.reg_bank  = 3'b001;
        dec_bundle.reg_flags = 1'b1;
      end
      2'b01: begin
        dec_bundle.alu       = {2'b00, op[3:0]};
        dec_bundle.mux4      = 1'b1;
        dec_bundle.mux6      = 3'b001;
        dec_bundle.reg_bank  = 3'b001;
        dec_bundle.reg_flags = 1'b1;
      end
      2'b10: begin
        dec_bundle.mux4 = 1'b1;
        dec_bundle.mux5 = 3'b001;
        dec_bundle.mux6 = 3'b010;
        if (op[0]) begin
          dec_bundle.data_mem = 1'b1;
        end else begin
          dec_bundle.reg_bank = 3'b001;
          dec_is_load         = 1'b1;
        end
      end
      default: begin
        if (op != OP_NOP) begin
          dec_bundle.alu       = op;
          dec_bundle.mux5      = 3'b010;
          dec_bundle.mux6      = 3'b011;
          dec_bundle.reg_bank  = 3'b010;
          dec_bundle.reg_flags = 1'b1;
          dec_is_multi         = 1'b1;
        end
      end
    endcase
  end

  assign hazard      = load_pend_q && instr_valid && ((rs == load_rd_q) || (rt == load_rd_q));
  assign instr_ready = (state_q == RUN) && !stall && !flush && !hazard;

  // Flush beats stall; a bubble in RUN drops the pending load so a hazard costs one cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_pend_d = load_pend_q;
    load_rd_d   = load_rd_q;
    bundle_d    = bundle_q;
    if (flush) begin
      state_d     = RUN;
      cnt_d       = 4'd0;
      load_pend_d = 1'b0;
      bundle_d    = BUBBLE;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (instr_valid && !hazard) begin
            bundle_d    = dec_bundle;
            load_pend_d = dec_is_load;
            if (dec_is_load) begin
              load_rd_d = rd;
            end
            if (dec_is_multi) begin
              state_d = MULTI;
              cnt_d   = CNT_INIT;
            end
          end else begin
            bundle_d    = BUBBLE;
            load_pend_d = 1'b0;
          end
        end
        MULTI: begin
          bundle_d = BUBBLE;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d  = RUN;
          bundle_d = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      load_pend_q <= 1'b0;
      load_rd_q   <= 3'd0;
      bundle_q    <= BUBBLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_pend_q <= load_pend_d;
      load_rd_q   <= load_rd_d;
      bundle_q    <= bundle_d;
    end
  end

  assign issue_valid = bundle_q.issue_valid;
  assign mux4        = bundle_q.mux4;
  assign mux5        = bundle_q.mux5;
  assign mux6        = bundle_q.mux6;
  assign reg_bank    = bundle_q.reg_bank;
  assign data_mem    = bundle_q.data_mem;
  assign reg_flags   = bundle_q.reg_flags;
  assign alu         = bundle_q.alu;

endmodule

// File: tb/tb_fo_issue_control.sv
// Bench for fo_issue_control: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the issue rules.
module tb_fo_issue_control;

  localparam int MC_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        stall;
  logic        flush;
  logic        issue_valid;
  logic        mux4;
  logic [2:0]  mux5;
  logic [2:0]  mux6;
  logic [2:0]  reg_bank;
  logic        data_mem;
  logic        reg_flags;
  logic [5:0]  alu;

  logic [18:0] act;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: remaining hold edges of a long op, pending load register, outputs
  int          m_busy = 0;
  bit          m_lpend = 1'b0;
  logic [2:0]  m_lrd = 3'd0;
  logic [18:0] m_out = '0;

  localparam logic [18:0] B_R5 = {1'b1, 1'b0, 3'b000, 3'b000, 3'b001, 1'b0, 1'b1, 6'b000101};
  localparam logic [18:0] B_I3 = {1'b1, 1'b1, 3'b000, 3'b001, 3'b001, 1'b0, 1'b1, 6'b000011};
  localparam logic [18:0] B_ST = {1'b1, 1'b1, 3'b001, 3'b010, 3'b000, 1'b1, 1'b0, 6'b000000};
  localparam logic [18:0] B_LD = {1'b1, 1'b1, 3'b001, 3'b010, 3'b001, 1'b0, 1'b0, 6'b000000};
  localparam logic [18:0] B_MC = {1'b1, 1'b0, 3'b010, 3'b011, 3'b010, 1'b0, 1'b1, 6'b110010};

  localparam logic [15:0] I_R5  = {6'b000101, 3'd1, 3'd3, 3'd5, 1'b0};
  localparam logic [15:0] I_R44 = {6'b000101, 3'd1, 3'd4, 3'd4, 1'b0};
  localparam logic [15:0] I_I3  = {6'b010011, 3'd2, 3'd0, 3'd0, 1'b0};
  localparam logic [15:0] I_ST  = {6'b100001, 3'd0, 3'd1, 3'd2, 1'b0};
  localparam logic [15:0] I_LD3 = {6'b100000, 3'd3, 3'd0, 3'd0, 1'b0};
  localparam logic [15:0] I_MC  = {6'b110010, 10'd0};

  fo_issue_control #(.MC_LAT(MC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .stall      (stall),
    .flush      (flush),
    .issue_valid(issue_valid),
    .mux4       (mux4),
    .mux5       (mux5),
    .mux6       (mux6),
    .reg_bank   (reg_bank),
    .data_mem   (data_mem),
    .reg_flags  (reg_flags),
    .alu        (alu)
  );

  assign act = {issue_valid, mux4, mux5, mux6, reg_bank, data_mem, reg_flags, alu};

  always #5 clk = ~clk;

  function automatic logic [18:0] ref_decode(input logic [15:0] w);
    logic [5:0] op;
    op = w[15:10];
    case (op[5:4])
      2'b00:   return {1'b1, 1'b0, 3'b000, 3'b000, 3'b001, 1'b0, 1'b1, op};
      2'b01:   return {1'b1, 1'b1, 3'b000, 3'b001, 3'b001, 1'b0, 1'b1, 2'b00, op[3:0]};
      2'b10:   return op[0] ? {1'b1, 1'b1, 3'b001, 3'b010, 3'b000, 1'b1, 1'b0, 6'b0}
                            : {1'b1, 1'b1, 3'b001, 3'b010, 3'b001, 1'b0, 1'b0, 6'b0};
      default: return (op == 6'b111111) ? {1'b1, 18'b0}
                                        : {1'b1, 1'b0, 3'b010, 3'b011, 3'b010, 1'b0, 1'b1, op};
    endcase
  endfunction

  function automatic bit m_hazard();
    return m_lpend && instr_valid && (instr[6:4] == m_lrd || instr[3:1] == m_lrd);
  endfunction

  function automatic bit m_ready();
    return (m_busy == 0) && !stall && !flush && !m_hazard();
  endfunction

  // Advance one clock: model reacts to the inputs present at the edge, then return at negedge
  task automatic tick();
    bit hz;
    @(posedge clk);
    hz = m_hazard();
    if (rst || flush) begin
      m_busy  = 0;
      m_lpend = 1'b0;
      m_out   = '0;
    end else if (stall) begin
      m_busy = m_busy;
    end else if (m_busy > 0) begin
      m_out  = '0;
      m_busy = m_busy - 1;
    end else if (instr_valid && !hz) begin
      m_out   = ref_decode(instr);
      m_lpend = (instr[15:14] == 2'b10) && !instr[10];
      m_lrd   = instr[9:7];
      if (instr[15:14] == 2'b11 && instr[15:10] != 6'b111111) m_busy = MC_LAT - 1;
    end else begin
      m_out   = '0;
      m_lpend = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int sel;
    w   = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel <= 2) begin
      w[15:14] = 2'b10; w[10] = 1'b0;
    end else if (sel == 3) begin
      w[15:14] = 2'b10; w[10] = 1'b1;
    end else if (sel == 4) begin
      w[15:10] = 6'b111111;
    end else if (sel == 5) begin
      w[15:14] = 2'b11;
      if (w[15:10] == 6'b111111) w[10] = 1'b0;
    end else begin
      w[15] = 1'b0;
    end
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; instr_valid = 1'b1; instr = I_R5;
    tick();
    tick();
    vectors++;
    if (act !== 19'd0) begin
      miscompares++; $display("[TB] FAIL reset_bundle: got %h want %h", act, 19'd0);
    end
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", instr_ready);
    end
    rst = 1'b0;
    #1;
    tick();
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL reset_first_accept: got %h want %h", act, B_R5);
    end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = I_R5;
    tick();
    instr = I_I3;
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL b2b_r: got %h want %h", act, B_R5);
    end
    tick();
    instr = I_ST;
    vectors++;
    if (act !== B_I3) begin
      miscompares++; $display("[TB] FAIL b2b_i: got %h want %h", act, B_I3);
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if (act !== B_ST) begin
      miscompares++; $display("[TB] FAIL b2b_store: got %h want %h", act, B_ST);
    end
    tick();
    vectors++;
    if (act !== 19'd0) begin
      miscompares++; $display("[TB] FAIL b2b_idle: got %h want %h", act, 19'd0);
    end
  endtask

  task automatic test_load_use();
    instr_valid = 1'b1; instr = I_LD3;
    tick();
    instr = I_R5;
    #1;
    vectors++;
    if (act !== B_LD) begin
      miscompares++; $display("[TB] FAIL lu_load: got %h want %h", act, B_LD);
    end
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL lu_ready_low: got %b want 0", instr_ready);
    end
    tick();
    #1;
    vectors++;
    if (act !== 19'd0) begin
      miscompares++; $display("[TB] FAIL lu_bubble: got %h want %h", act, 19'd0);
    end
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL lu_ready_back: got %b want 1", instr_ready);
    end
    tick();
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL lu_r_after: got %h want %h", act, B_R5);
    end
    instr_valid = 1'b0;
    tick();
    instr_valid = 1'b1; instr = I_LD3;
    tick();
    instr = I_R44;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL lu_nohaz_ready: got %b want 1", instr_ready);
    end
    tick();
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL lu_nohaz_r: got %h want %h", act, B_R5);
    end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_multi();
    instr_valid = 1'b1; instr = I_MC;
    tick();
    instr = I_R44;
    for (int c = 1; c <= MC_LAT; c++) begin
      #1;
      vectors++;
      if (act !== ((c == 1) ? B_MC : 19'd0)) begin
        miscompares++; $display("[TB] FAIL multi_out_c%0d: got %h want %h", c, act, (c == 1) ? B_MC : 19'd0);
      end
      vectors++;
      if (instr_ready !== (c == MC_LAT)) begin
        miscompares++; $display("[TB] FAIL multi_ready_c%0d: got %b want %b", c, instr_ready, c == MC_LAT);
      end
      tick();
    end
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL multi_next: got %h want %h", act, B_R5);
    end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    instr_valid = 1'b1; instr = I_R5;
    tick();
    instr = I_I3; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (act !== B_R5 || instr_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stall_hold_%0d: got %h/%b want %h/0", c, act, instr_ready, B_R5);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    vectors++;
    if (act !== B_R5 || instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL stall_release: got %h/%b want %h/1", act, instr_ready, B_R5);
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if (act !== B_I3) begin
      miscompares++; $display("[TB] FAIL stall_next: got %h want %h", act, B_I3);
    end
    tick();
    vectors++;
    if (act !== 19'd0) begin
      miscompares++; $display("[TB] FAIL stall_nodup: got %h want %h", act, 19'd0);
    end
    // Long op with a 3-cycle stall right after issue
    instr_valid = 1'b1; instr = I_MC;
    tick();
    instr = I_R44; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (act !== B_MC || instr_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stall_multi_hold_%0d: got %h/%b want %h/0", c, act, instr_ready, B_MC);
      end
      tick();
    end
    stall = 1'b0;
    for (int c = 0; c < MC_LAT - 1; c++) begin
      #1;
      vectors++;
      if (instr_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stall_multi_busy_%0d: got %b want 0", c, instr_ready);
      end
      tick();
    end
    #1;
    vectors++;
    if (act !== 19'd0 || instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL stall_multi_end: got %h/%b want 0/1", act, instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    instr_valid = 1'b1; instr = I_MC;
    tick();
    instr = I_R44; stall = 1'b1; flush = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_ready_low: got %b want 0", instr_ready);
    end
    tick();
    stall = 1'b0; flush = 1'b0;
    #1;
    vectors++;
    if (act !== 19'd0 || instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_multi_abort: got %h/%b want 0/1", act, instr_ready);
    end
    tick();
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL flush_resume: got %h want %h", act, B_R5);
    end
    instr = I_LD3;
    tick();
    instr = I_R5; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (act !== 19'd0 || instr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_hazard_clear: got %h/%b want 0/1", act, instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if (act !== B_R5) begin
      miscompares++; $display("[TB] FAIL flush_hazard_issue: got %h want %h", act, B_R5);
    end
    tick();
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      stall = ($urandom_range(0, 99) < 15);
      if (!instr_valid && $urandom_range(0, 99) < 75) begin
        instr_valid = 1'b1;
        instr       = rand_instr();
      end
      #1;
      vectors++;
      if (act !== m_out) begin
        miscompares++; $display("[TB] FAIL rand_bundle @%0d: got %h want %h", i, act, m_out);
      end
      vectors++;
      if (instr_ready !== m_ready()) begin
        miscompares++; $display("[TB] FAIL rand_ready @%0d: got %b want %b", i, instr_ready, m_ready());
      end
      acc = instr_valid && m_ready() && !rst;
      tick();
      if (acc) begin
        instr_valid = ($urandom_range(0, 99) < 75);
        instr       = rand_instr();
      end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_multi();
    test_stall();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
